mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Bus initiator for the multiplexed 16-bit AddrData memory bus: the CPU side that drives address, AddrValid and rw, then either drives or captures four data beats. It replaces the hand-written testbench CPU so the page-decoded memory controllers can be exercised, and later shared, by a synthesizable master. A simple valid/ready command port on the core side is translated into fixed-length burst cycles on the bus side.

## Interface
- BURST_LEN, 4: data beats per burst. Legal range 1–8. Must be 4 when talking to the page memory controllers.
- clk  in  1  bus and block clock.
- resetH  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  16  burst start address; [15:12] selects the page.
- cmd_wdata  in  16*BURST_LEN  write data; word k occupies [16k+15:16k].
- rsp_valid  out  1  one-cycle completion pulse for every burst, read or write.
- rsp_rdata  out  16*BURST_LEN  captured read words, same packing as cmd_wdata.
- AddrData  inout  16  tri; multiplexed address/data bus.
- AddrValid  out  1  address phase strobe.
- rw  out  1  bus read/write qualifier.

## Operation
- States: IDLE, ADDR, BEAT, and TURN (TURN exists only with the macro).
- beat_cnt is max(1, $clog2(BURST_LEN)) bits wide and counts 0..BURST_LEN-1.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready at a posedge, latch cmd_rw, cmd_addr and cmd_wdata, then go to ADDR.
  - cmd_valid is ignored in every other state. No command queue.
- ADDR (1 cycle):
  - AddrValid=1.
  - AddrData=latched addr.
  - rw=latched rw.
  - Next state BEAT, beat_cnt=0.
- BEAT (BURST_LEN cycles):
  - AddrValid=0. rw holds the latched value.
  - Write: AddrData = wdata word[beat_cnt].
  - Read: AddrData is 'z. At the posedge ending each beat, sample AddrData into rdata word[beat_cnt] verbatim, X/Z included. An unclaimed page therefore returns z.
  - On the last beat, go to IDLE (or TURN, see Configuration). On that same edge set rsp_valid=1 for one cycle.
- rsp_rdata:
  - Updated only by reads.
  - Stable from the rsp_valid pulse until the next read's first capture.
  - Writes leave it unchanged.
- Only this block and the addressed responder may drive AddrData. The master never drives it in a read BEAT or in IDLE.

## Timing
- Reset (sync, checked at posedge), effective the cycle after the edge:
  - state=IDLE, AddrValid=0, rw=0, AddrData released, rsp_valid=0, rsp_rdata=0.
  - cmd_ready=0 while resetH is high.
- Reset mid-burst: the bus is released on the next edge. No rsp_valid is produced and partial read data is discarded (rdata cleared).
- Command accepted at edge E0:
  - ADDR occupies E0–E1.
  - Beats occupy E1 to E1+BURST_LEN.
  - rsp_valid is high for exactly one cycle starting at E1+BURST_LEN.
  - cmd_ready is high in that same cycle.
- Back-to-back commands:
  - The minimum spacing between AddrValid pulses is BURST_LEN+2 cycles (one IDLE cycle between bursts).
  - With the macro, a read burst adds 1 more cycle.
- Responder alignment: the controller samples the address on the edge ending ADDR and drives/accepts beat k in its k-th data state. This coincides with master BEAT k.

## Configuration
- READ_TURNAROUND_EN defined:
  - After a read's last beat, spend one cycle in TURN before IDLE.
  - In TURN: AddrValid=0, AddrData 'z, cmd_ready=0.
  - rsp_valid still pulses at the last-beat edge (during TURN).
  - Guarantees a fully undriven bus cycle before the master drives again.
  - Writes are unaffected.
- Undefined: no TURN state. Last beat goes straight to IDLE for both directions.

## Test plan
- Write 0x2010, data 0x1111/0x2222/0x3333/0x4444 -> one ADDR cycle with AddrData=0x2010, AddrValid=1, rw=0; then 4 beats carrying the words in order; rsp_valid pulses once 5 cycles after acceptance.
- Read 0x2010 after the write (page-2 controller attached) -> AddrData 'z from the master during beats; rsp_rdata={0x4444,0x3333,0x2222,0x1111} (word0 at LSBs); one rsp_valid pulse.
- Read 0x5000 with only a page-2 controller -> bus floats; rsp_rdata words all 16'hzzzz; rsp_valid still pulses.
- Read immediately followed by write, cmd_valid held high -> AddrValid pulses spaced 6 cycles without the macro, 7 with READ_TURNAROUND_EN; no cycle where both sides drive AddrData.
- resetH asserted during read beat 2 -> next cycle AddrValid=0, AddrData 'z, rsp_rdata=0, no rsp_valid; a subsequent write to 0x2020 completes normally.
- cmd_valid toggled during a write burst -> ignored; only the first command appears on the bus; cmd_ready low throughout ADDR and BEAT.

Source files
------------

// File: rtl/mem_bus_master.sv
// mem_bus_master: valid/ready command port to fixed-length burst cycles on the
// multiplexed 16-bit AddrData bus (ADDR phase, then BURST_LEN data beats).
// Optional feature macro: READ_TURNAROUND_EN adds one undriven TURN cycle after
// each read burst before the master may drive the bus again.
module mem_bus_master #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      resetH,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rw,
  input  logic [15:0]               cmd_addr,
  input  logic [16*BURST_LEN-1:0]   cmd_wdata,
  output logic                      rsp_valid,
  output logic [16*BURST_LEN-1:0]   rsp_rdata,
  inout  wire  [15:0]               AddrData,
  output logic                      AddrValid,
  output logic                      rw
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    BEAT = 2'd2
`ifdef READ_TURNAROUND_EN
    , TURN = 2'd3
`endif
  } state_t;

  state_t                               state;
  logic [CNT_W-1:0]                     beat_cnt;
  logic [BURST_LEN-1:0][WORD_W-1:0]     wdata_q;
  logic [BURST_LEN-1:0][WORD_W-1:0]     rdata_q;
  logic                                 drive_en;
  logic [WORD_W-1:0]                    drive_data;

  // Bus driver: only ADDR and write beats ever enable the master's output.
  assign AddrData  = drive_en ? drive_data : {WORD_W{1'bz}};
  assign rsp_rdata = rdata_q;

  // Burst sequencer with registered bus strobes, drive enable and response.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      drive_en   <= 1'b0;
      drive_data <= '0;
      AddrValid  <= 1'b0;
      rw         <= 1'b0;
      rsp_valid  <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            rw         <= cmd_rw;
            wdata_q    <= cmd_wdata;
            drive_data <= cmd_addr;
            drive_en   <= 1'b1;
            AddrValid  <= 1'b1;
            cmd_ready  <= 1'b0;
            state      <= ADDR;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ADDR: begin
          AddrValid <= 1'b0;
          beat_cnt  <= '0;
          state     <= BEAT;
          if (rw) begin
            drive_en <= 1'b0;
          end else begin
            drive_en   <= 1'b1;
            drive_data <= wdata_q[0];
          end
        end

        BEAT: begin
          // Capture verbatim so an unclaimed page reads back as floating.
          if (rw) begin
            rdata_q[beat_cnt] <= AddrData;
          end
          if (beat_cnt == LAST_BEAT) begin
            drive_en  <= 1'b0;
            rsp_valid <= 1'b1;
            beat_cnt  <= '0;
`ifdef READ_TURNAROUND_EN
            if (rw) begin
              state     <= TURN;
              cmd_ready <= 1'b0;
            end else begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
`else
            state     <= IDLE;
            cmd_ready <= 1'b1;
`endif
          end else begin
            beat_cnt   <= beat_cnt + 1'b1;
            drive_data <= wdata_q[beat_cnt + 1'b1];
          end
        end

`ifdef READ_TURNAROUND_EN
        TURN: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a page-2 memory responder on the bus.
module tb_mem_bus_master;

  localparam int unsigned BL = 4;

  logic              clk = 1'b0;
  logic              resetH;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [15:0]       cmd_addr;
  logic [16*BL-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [16*BL-1:0]  rsp_rdata;
  wire  [15:0]       AddrData;
  logic              AddrValid;
  logic              rw;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_bus_master #(.BURST_LEN(BL)) dut (
    .clk(clk), .resetH(resetH),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .AddrData(AddrData), .AddrValid(AddrValid), .rw(rw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Page-2 responder: latches address at the edge ending ADDR, then serves
  // or absorbs one word per beat.
  logic [15:0] mem [0:255];
  logic [15:0] r_addr;
  logic        r_act, r_rw, r_drv;
  logic [2:0]  r_k;
  logic [15:0] r_out;

  assign AddrData = r_drv ? r_out : 16'bz;

  always @(posedge clk) begin
    if (resetH) begin
      r_act <= 1'b0;
      r_drv <= 1'b0;
    end else if (AddrValid && AddrData[15:12] == 4'h2) begin
      r_act  <= 1'b1;
      r_rw   <= rw;
      r_addr <= AddrData;
      r_k    <= 3'd0;
      r_drv  <= rw;
      r_out  <= mem[AddrData[7:0]];
    end else if (r_act) begin
      if (!r_rw) mem[8'(r_addr[7:0] + 8'(r_k))] <= AddrData;
      if (r_k == 3'd3) begin
        r_act <= 1'b0;
        r_drv <= 1'b0;
      end else begin
        r_k   <= r_k + 3'd1;
        r_out <= mem[8'(r_addr[7:0] + 8'(r_k) + 8'd1)];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // An undriven bus reads as all-z, or as 0 on a two-state simulator.
  task automatic chk_float(input string tag, input logic [15:0] obs);
    n_checks++;
    assert (obs === 16'hzzzz || obs === 16'h0000) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected zzzz", tag, obs);
    end
  endtask

  // Present one command at a negedge; returns at the negedge of the ADDR cycle.
  task automatic issue(input logic rwv, input logic [15:0] a, input logic [63:0] wd);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", 64'(cmd_ready), 64'd1);
    cmd_rw = rwv; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Checks ADDR cycle, each beat and the response pulse, starting in ADDR.
  task automatic check_burst(input string tag, input logic rwv, input logic [15:0] a,
                             input logic [63:0] words, input logic floating);
    logic exp_ready;
    chk({tag, "_av"}, 64'(AddrValid), 64'd1);
    chk({tag, "_addr"}, 64'(AddrData), 64'(a));
    chk({tag, "_rw"}, 64'(rw), 64'(rwv));
    chk({tag, "_ready_addr"}, 64'(cmd_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_beat_av"}, 64'(AddrValid), 64'd0);
      chk({tag, "_beat_rsp"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_beat_ready"}, 64'(cmd_ready), 64'd0);
      if (floating) chk_float({tag, "_beat_float"}, AddrData);
      else          chk({tag, "_beat_data"}, 64'(AddrData), 64'(words[k*16 +: 16]));
    end
    @(negedge clk);
    chk({tag, "_rsp"}, 64'(rsp_valid), 64'd1);
`ifdef READ_TURNAROUND_EN
    exp_ready = !rwv;
`else
    exp_ready = 1'b1;
`endif
    chk({tag, "_rsp_ready"}, 64'(cmd_ready), 64'(exp_ready));
    @(negedge clk);
    chk({tag, "_rsp_end"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, av_count;
    logic got, ready_low;
    logic [63:0] saved;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    resetH = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_av", 64'(AddrValid), 64'd0);
    chk("rst_rw", 64'(rw), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk_float("rst_bus", AddrData);
    resetH = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Write burst to page 2
    issue(1'b0, 16'h2010, 64'h4444_3333_2222_1111);
    check_burst("wr1", 1'b0, 16'h2010, 64'h4444_3333_2222_1111, 1'b0);
    chk("wr1_rdata_unchanged", rsp_rdata, 64'd0);

    // Read it back
    issue(1'b1, 16'h2010, 64'h0);
    check_burst("rd1", 1'b1, 16'h2010, 64'h4444_3333_2222_1111, 1'b0);
    chk("rd1_rdata", rsp_rdata, 64'h4444_3333_2222_1111);

    // Unclaimed page floats
    issue(1'b1, 16'h5000, 64'h0);
    check_burst("rd_unclaimed", 1'b1, 16'h5000, 64'h0, 1'b1);
    for (int k = 0; k < 4; k++) chk_float("rd_unclaimed_word", rsp_rdata[k*16 +: 16]);

    // Read then write back-to-back, cmd_valid held
    repeat (2) @(negedge clk);
    issue(1'b1, 16'h2010, 64'h0);
    t0 = cyc;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h2030; cmd_wdata = 64'hDDDD_CCCC_BBBB_AAAA;
    got = 1'b0; t1 = 0; saved = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) saved = rsp_rdata;
      if (AddrValid) begin
        got = 1'b1; t1 = cyc; cmd_valid = 1'b0;
      end
    end
    chk("b2b_second_av_seen", 64'(got), 64'd1);
`ifdef READ_TURNAROUND_EN
    chk("b2b_spacing", 64'(t1 - t0), 64'd7);
`else
    chk("b2b_spacing", 64'(t1 - t0), 64'd6);
`endif
    chk("b2b_rd_rdata", saved, 64'h4444_3333_2222_1111);
    chk("b2b_wr_addr", 64'(AddrData), 64'h2030);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("b2b_wr_done", 64'(got), 64'd1);
    @(negedge clk);
    issue(1'b1, 16'h2030, 64'h0);
    check_burst("rd_b2b_wr", 1'b1, 16'h2030, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
    chk("rd_b2b_wr_rdata", rsp_rdata, 64'hDDDD_CCCC_BBBB_AAAA);

    // Reset during read beat 2
    issue(1'b1, 16'h2010, 64'h0);
    repeat (3) @(negedge clk);
    resetH = 1'b1;
    @(negedge clk);
    chk("mrst_av", 64'(AddrValid), 64'd0);
    chk("mrst_rsp", 64'(rsp_valid), 64'd0);
    chk("mrst_rdata", rsp_rdata, 64'd0);
    chk("mrst_ready", 64'(cmd_ready), 64'd0);
    chk_float("mrst_bus", AddrData);
    resetH = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("mrst_no_rsp", 64'(got), 64'd0);
    issue(1'b0, 16'h2020, 64'h8888_7777_6666_5555);
    check_burst("wr_after_rst", 1'b0, 16'h2020, 64'h8888_7777_6666_5555, 1'b0);
    issue(1'b1, 16'h2020, 64'h0);
    check_burst("rd_after_rst", 1'b1, 16'h2020, 64'h8888_7777_6666_5555, 1'b0);
    chk("rd_after_rst_rdata", rsp_rdata, 64'h8888_7777_6666_5555);

    // cmd_valid toggling during a write burst is ignored
    issue(1'b0, 16'h2040, 64'h0404_0303_0202_0101);
    av_count = 1; ready_low = !cmd_ready;
    cmd_addr = 16'h5555; cmd_rw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (AddrValid) av_count++;
      if (cmd_ready) ready_low = 1'b0;
      chk("tog_beat_data", 64'(AddrData), 64'(16'h0101 * 16'(k + 1)));
      cmd_valid = (k % 2 == 0) && (k < 3);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("tog_rsp", 64'(rsp_valid), 64'd1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (AddrValid) n++;
    end
    chk("tog_one_av", 64'(av_count + n), 64'd1);
    chk("tog_ready_low", 64'(ready_low), 64'd1);
    chk("tog_rdata_unchanged", rsp_rdata, 64'h8888_7777_6666_5555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
